// File: rtl/shift_rows_stream.sv
// Byte-serial ShiftRows / InvShiftRows: loads one 4xNB state, then drains it row-shifted.
// Latency: first output byte on the cycle after the last input byte is accepted.
// Backpressure: in_ready is low while draining; out_ready=0 holds out_byte/out_last stable.
module shift_rows_stream #(
  parameter int NB     = 4,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              in_inv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_byte,
  output logic              out_last,
  output logic              busy
);

  localparam int NBYTES = 4 * NB;
  localparam int IW     = $clog2(NBYTES);
  localparam int CW     = $clog2(NB);

  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
  localparam logic [CW:0]   NB_W     = (CW+1)'(NB);
  localparam logic [CW:0]   S1       = (CW+1)'(1);
  localparam logic [CW:0]   S2       = (NB == 8) ? (CW+1)'(3) : (CW+1)'(2);
  localparam logic [CW:0]   S3       = (NB == 8) ? (CW+1)'(4) : (CW+1)'(3);

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IW-1:0]   wr_idx;
  logic [IW-1:0]   rd_idx;
  logic            mode_q;
  logic [BYTE_W-1:0] mem [NBYTES];

  logic            in_hs;
  logic            out_hs;
  logic [1:0]      row;
  logic [CW:0]     col;
  logic [CW:0]     shift;
  logic [CW:0]     src_col;
  logic [IW-1:0]   src_idx;

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DRAIN);
  assign out_last  = (state_q == DRAIN) && (rd_idx == LAST_IDX);
  assign busy      = (state_q == DRAIN) || (wr_idx != '0);

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD:    if (in_hs && (wr_idx == LAST_IDX)) state_d = DRAIN;
        DRAIN:   if (out_hs && (rd_idx == LAST_IDX)) state_d = LOAD;
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx <= '0;
      rd_idx <= '0;
      mode_q <= 1'b0;
    end else if (clear) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (in_hs) begin
        wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
        if (wr_idx == '0) mode_q <= in_inv;
      end
      if (out_hs) begin
        rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
      end
    end
  end

  // State storage needs no reset; it is only read after a full block is loaded.
  always_ff @(posedge clk) begin
    if (in_hs && !clear) mem[wr_idx] <= in_byte;
  end

  // Source column = (col +/- shift) mod NB, kept non-negative by adding NB before subtracting.
  always_comb begin
    row = rd_idx[1:0];
    col = {1'b0, rd_idx[IW-1:2]};
    case (row)
      2'd0:    shift = '0;
      2'd1:    shift = S1;
      2'd2:    shift = S2;
      default: shift = S3;
    endcase
    if (mode_q) src_col = col + NB_W - shift;
    else        src_col = col + shift;
    if (src_col >= NB_W) src_col = src_col - NB_W;
    src_idx = {src_col[CW-1:0], row};
  end

  assign out_byte = (state_q == DRAIN) ? mem[src_idx] : '0;

endmodule

// File: tb/tb_shift_rows_stream.sv
// Bench for shift_rows_stream at NB=4, 6 and 8: directed vectors, round trips,
// randomized gaps against a column/row index model, clear and async reset.
module tb_shift_rows_stream;

  localparam int NU = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear     [NU];
  logic       in_valid  [NU];
  logic       in_ready  [NU];
  logic [7:0] in_byte   [NU];
  logic       in_inv    [NU];
  logic       out_valid [NU];
  logic       out_ready [NU];
  logic [7:0] out_byte  [NU];
  logic       out_last  [NU];
  logic       busy      [NU];

  logic [7:0] din  [32];
  logic [7:0] dexp [32];
  logic [7:0] orig [32];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    shift_rows_stream #(
      .NB    ((g == 0) ? 4 : ((g == 1) ? 6 : 8)),
      .BYTE_W(8)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_byte  (in_byte[g]),
      .in_inv   (in_inv[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_byte (out_byte[g]),
      .out_last (out_last[g]),
      .busy     (busy[g])
    );
  end

  function automatic int nbv(input int u);
    return (u == 0) ? 4 : ((u == 1) ? 6 : 8);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: output byte (c,r) comes from column (c +/- s(r)) mod NB of the same row.
  task automatic model(input int u, input logic inv);
    int nb, c, r, s, sc;
    nb = nbv(u);
    for (int k = 0; k < 4 * nb; k++) begin
      c = k / 4;
      r = k % 4;
      s = (r < 2) ? r : ((nb == 8) ? r + 1 : r);
      sc = inv ? (c - s + nb) % nb : (c + s) % nb;
      dexp[k] = din[4 * sc + r];
    end
  endtask

  task automatic send(input int u, input int n, input logic inv, input int gap);
    int t;
    for (int k = 0; k < n; k++) begin
      while (gap > 0 && $urandom_range(99) < gap) begin
        in_valid[u] = 1'b0;
        in_inv[u]   = 1'($urandom);
        @(posedge clk); #1;
      end
      in_valid[u] = 1'b1;
      in_byte[u]  = din[k];
      in_inv[u]   = (k == 0) ? inv : 1'($urandom);
      t = 0;
      while (!in_ready[u] && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 200) check("send_timeout", 0, 1);
      @(posedge clk); #1;
    end
    in_valid[u] = 1'b0;
    in_inv[u]   = 1'b0;
  endtask

  task automatic recv(input int u, input int n, input int gap);
    logic [8:0] held;
    logic       stalled;
    int         k, t;
    stalled = 1'b0;
    held    = '0;
    k = 0;
    t = 0;
    check("first_vld", out_valid[u], 1);
    while (k < n && t < 2000) begin
      out_ready[u] = ($urandom_range(99) >= gap);
      if (stalled) check("stall_stable", {out_last[u], out_byte[u]}, held);
      check("out_vld", out_valid[u], 1);
      check("in_rdy_drain", in_ready[u], 0);
      if (out_valid[u] && out_ready[u]) begin
        check("byte", out_byte[u], dexp[k]);
        check("last", out_last[u], (k == n - 1));
        k++;
        stalled = 1'b0;
      end else begin
        held    = {out_last[u], out_byte[u]};
        stalled = 1'b1;
      end
      @(posedge clk); #1;
      t++;
    end
    out_ready[u] = 1'b0;
    if (k < n) check("recv_timeout", 0, 1);
    check("in_rdy_back", in_ready[u], 1);
    check("out_vld_off", out_valid[u], 0);
  endtask

  task automatic set_din(input logic [127:0] v);
    for (int k = 0; k < 16; k++) din[k] = v[127 - 8 * k -: 8];
  endtask

  task automatic set_exp(input logic [127:0] v);
    for (int k = 0; k < 16; k++) dexp[k] = v[127 - 8 * k -: 8];
  endtask

  task automatic rand_block(input int u, input int gi, input int go);
    logic inv;
    inv = 1'($urandom);
    for (int k = 0; k < 4 * nbv(u); k++) din[k] = 8'($urandom);
    send(u, 4 * nbv(u), inv, gi);
    model(u, inv);
    recv(u, 4 * nbv(u), go);
  endtask

  task automatic roundtrip(input int u);
    int n;
    n = 4 * nbv(u);
    for (int k = 0; k < n; k++) din[k] = 8'($urandom);
    orig = din;
    send(u, n, 1'b0, 0);
    model(u, 1'b0);
    recv(u, n, 0);
    din = dexp;
    send(u, n, 1'b1, 25);
    dexp = orig;
    recv(u, n, 25);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < NU; u++) begin
      clear[u] = 1'b0; in_valid[u] = 1'b0; in_byte[u] = '0;
      in_inv[u] = 1'b0; out_ready[u] = 1'b0;
    end
    #1;
    for (int u = 0; u < NU; u++) begin
      check("rst_in_rdy", in_ready[u], 1);
      check("rst_out_vld", out_valid[u], 0);
      check("rst_last", out_last[u], 0);
      check("rst_busy", busy[u], 0);
      check("rst_byte", out_byte[u], 0);
    end
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // NB=4 directed vectors
    for (int k = 0; k < 16; k++) din[k] = 8'(k);
    send(0, 16, 1'b0, 0);
    set_exp(128'h00050a0f_04090e03_080d0207_0c01060b);
    recv(0, 16, 0);

    for (int k = 0; k < 16; k++) din[k] = 8'(k);
    send(0, 16, 1'b1, 0);
    set_exp(128'h000d0a07_04010e0b_0805020f_0c090603);
    recv(0, 16, 0);

    set_din(128'hd42711ae_e0bf98f1_b8b45de5_1e415230);
    send(0, 16, 1'b0, 0);
    set_exp(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5);
    recv(0, 16, 0);
    din = dexp;
    send(0, 16, 1'b1, 0);
    set_exp(128'hd42711ae_e0bf98f1_b8b45de5_1e415230);
    recv(0, 16, 0);

    // NB=8 incrementing block, first column pinned to known bytes
    for (int k = 0; k < 32; k++) din[k] = 8'(k);
    send(2, 32, 1'b0, 0);
    model(2, 1'b0);
    dexp[0] = 8'h00; dexp[1] = 8'h05; dexp[2] = 8'h0e; dexp[3] = 8'h13;
    recv(2, 32, 0);

    roundtrip(1);
    roundtrip(2);

    for (int b = 0; b < 100; b++) rand_block(0, 50, 50);
    for (int b = 0; b < 10; b++) begin
      rand_block(1, 50, 50);
      rand_block(2, 50, 50);
    end

    // clear after 7 bytes, with a competing input byte in the clear cycle
    for (int k = 0; k < 16; k++) din[k] = 8'($urandom);
    send(0, 7, 1'b1, 0);
    check("busy_partial", busy[0], 1);
    clear[0] = 1'b1; in_valid[0] = 1'b1; in_byte[0] = 8'hee;
    @(posedge clk); #1;
    clear[0] = 1'b0; in_valid[0] = 1'b0;
    check("clr_busy", busy[0], 0);
    check("clr_in_rdy", in_ready[0], 1);
    rand_block(0, 0, 0);

    // async reset in the middle of a drain
    for (int k = 0; k < 16; k++) din[k] = 8'($urandom);
    send(0, 16, 1'b0, 0);
    out_ready[0] = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    out_ready[0] = 1'b0;
    check("pre_rst_vld", out_valid[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_vld", out_valid[0], 0);
    check("arst_in_rdy", in_ready[0], 1);
    check("arst_busy", busy[0], 0);
    check("arst_last", out_last[0], 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rand_block(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
